uart_tx_buffered: RTL

- Buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them 8N1 on a single line, LSB first.
- Sits between byte producers (command responders, echo paths, status reporters) and the board TX pin.
- Adds backpressure and back-to-back framing, which an unbuffered transmitter lacks.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_tx_buffered.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// The optional parity state is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Baud counter width; never narrower than one bit so a 1-clock bit still elaborates.
    function automatic int baud_cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module uart_tx_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [AW:0]       count,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only and is never reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a FIFO, LSB-first serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int I_CLK_FREQ = 100_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [7:0]                  i_data,
    input  logic                        i_data_valid,
    output logic                        o_data_ready,
    output logic                        o_data,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int CPB    = clks_per_bit(I_CLK_FREQ, BAUDRATE);
    localparam int BAUD_W = baud_cnt_width(CPB);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    tx_state_t         state;
    tx_state_t         state_n;
    logic [7:0]        shift;
    logic [7:0]        shift_n;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_n;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_cnt_n;
    logic              line_n;
    logic              bit_done;
    logic              pop;
    logic              push;
    logic [7:0]        fifo_rdata;
    logic              fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic              parity;
    logic              parity_n;
`endif

    assign o_data_ready = (o_fifo_count != CNT_FULL);
    assign push         = i_data_valid && o_data_ready;
    assign o_busy       = (state != IDLE) || (o_fifo_count != '0);
    assign bit_done     = (baud_cnt == BAUD_LAST);

    uart_tx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .wdata (i_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (o_fifo_count),
        .empty (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            o_data   <= STOP_BIT;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            baud_cnt <= baud_cnt_n;
            o_data   <= line_n;
        end
    end

    // Shift register (and parity) hold data only, so they are left out of reset.
    always_ff @(posedge i_clk) begin
        shift  <= shift_n;
`ifdef UART_TX_PARITY_EN
        parity <= parity_n;
`endif
    end

    // o_data is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        baud_cnt_n = baud_cnt;
        line_n     = STOP_BIT;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity;
`endif

        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_n = ^fifo_rdata;
`endif
                    state_n = START;
                end
            end

            START: begin
                line_n = START_BIT;
                if (bit_done) begin
                    baud_cnt_n = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                line_n = shift[0];
                if (bit_done) begin
                    baud_cnt_n = '0;
                    shift_n    = shift >> 1;
                    bit_cnt_n  = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_n = parity;
                if (bit_done) begin
                    baud_cnt_n = '0;
                    state_n    = STOP;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
`endif

            STOP: begin
                line_n = STOP_BIT;
                if (bit_done) begin
                    baud_cnt_n = '0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                        parity_n = ^fifo_rdata;
`endif
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_n    = IDLE;
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
            end
        endcase
    end

endmodule
